aes_inv_subbytes: RTL and testbench

- Decryption-path counterpart of the forward SubBytes stage. Applies the AES inverse S-box (FIPS-197 Fig. 14) to every byte of a DIM x DIM state array.
- Byte-serial: one byte per cycle.
- Uses the same valid/ready stage handshake as the encrypt-path round stages, so it drops into the inverse-cipher round chain between InvShiftRows and AddRoundKey.

---
 rtl/aes_inv_subbytes_pkg.sv | 53 +++++
 rtl/aes_inv_subbytes_if.sv | 22 ++
 rtl/aes_inv_sbox.sv | 9 +
 rtl/aes_inv_subbytes.sv | 99 +++++++++
 tb/tb_aes_inv_subbytes.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_subbytes_pkg.sv
// Shared AES stage definitions: handshake FSM states, default state-array
// dimension and the forward/inverse S-box tables used by both cipher paths.
package aes_pkg;

   localparam int STATE_ARRAY_DIMENSION = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Forward S-box, indexed by input byte.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Inverse S-box, indexed by input byte; INV_SBOX[SBOX[x]] == x.
   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/aes_inv_subbytes_if.sv
// Valid/ready stage handshake carrying a DIM x DIM byte state array,
// indexed [row][column]. master = upstream/downstream side, slave = stage.
interface aes_inv_subbytes_if #(
   parameter int DIM = aes_pkg::STATE_ARRAY_DIMENSION
);
   logic                          valid;
   logic                          next_is_ready;
   logic [DIM-1:0][DIM-1:0][7:0]  state_array;
   logic [DIM-1:0][DIM-1:0][7:0]  state_array_out;
   logic                          ready;
   logic                          valid_out;

   modport master (
      output valid, next_is_ready, state_array,
      input  ready, valid_out, state_array_out
   );

   modport slave (
      input  valid, next_is_ready, state_array,
      output ready, valid_out, state_array_out
   );
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: a pure 256-entry table lookup.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] cipher_byte,
   output logic [7:0] plain_byte
);
   assign plain_byte = INV_SBOX[cipher_byte];
endmodule

// File: rtl/aes_inv_subbytes.sv
// Byte-serial InvSubBytes stage: captures a state array, substitutes one
// byte per cycle in column-major order, then presents the result until the
// downstream stage takes it.
module aes_inv_subbytes
   import aes_pkg::*;
#(
   parameter int DIM = STATE_ARRAY_DIMENSION
) (
   input  logic               clock,
   input  logic               reset,
   aes_inv_subbytes_if.slave  bus
);
   localparam int             CW   = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIM - 1);

   state_t                        state;
   state_t                        state_next;
   logic [CW-1:0]                 row;
   logic [CW-1:0]                 col;
   logic [DIM-1:0][DIM-1:0][7:0]  captured;
   logic [DIM-1:0][DIM-1:0][7:0]  result;
   logic [7:0]                    cur_byte;
   logic [7:0]                    sub_byte;
   logic                          capture;
   logic                          write;
   logic                          last_byte;

   assign cur_byte  = captured[row][col];
   assign last_byte = (row == LAST) && (col == LAST);

   aes_inv_sbox u_inv_sbox (
      .cipher_byte (cur_byte),
      .plain_byte  (sub_byte)
   );

   // Stage FSM state register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_next = state;
      capture    = 1'b0;
      write      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.valid) begin
               capture    = 1'b1;
               state_next = RUNNING;
            end
         end
         RUNNING: begin
            write = 1'b1;
            if (last_byte) state_next = DONE;
         end
         DONE: begin
            if (bus.next_is_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture register, coordinate walk and result array.
   always_ff @(posedge clock) begin
      // NOTE: the byte arrays are plain flops, not RAM, so they take the
      // synchronous reset like any other register.
      if (reset) begin
         row      <= '0;
         col      <= '0;
         captured <= '0;
         result   <= '0;
      end else begin
         if (capture) begin
            captured <= bus.state_array;
            row      <= '0;
            col      <= '0;
         end
         if (write) begin
            result[row][col] <= sub_byte;
            if (row == LAST) begin
               row <= '0;
               col <= last_byte ? '0 : col + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end
      end
   end

   assign bus.ready           = (state == IDLE);
   assign bus.valid_out       = (state == DONE);
   assign bus.state_array_out = result;

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Directed bench for the byte-serial InvSubBytes stage.
module tb_aes_inv_subbytes;
   import aes_pkg::*;

   typedef logic [3:0][3:0][7:0] arr_t;

   // Inverse S-box of 0x00..0x0f, from the FIPS-197 inverse table.
   localparam logic [7:0] EXP_LO [16] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb
   };

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   int   cyc;

   aes_inv_subbytes_if #(.DIM(4)) bus ();

   aes_inv_subbytes #(.DIM(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   function automatic arr_t fill(input logic [7:0] b);
      arr_t a;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            a[r][c] = b;
      return a;
   endfunction

   // Step until valid_out is seen; n = edges taken. Expiry is a failed check.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.valid_out && n < 40);
      check("wait_valid_out", bus.valid_out, 1'b1);
   endtask

   initial begin
      arr_t a_in;
      arr_t a_exp;
      int   n;
      int   prev_acc;
      int   acc;

      checks = 0;
      errors = 0;
      cyc    = 0;
      reset  = 1'b1;
      bus.valid         = 1'b0;
      bus.next_is_ready = 1'b0;
      bus.state_array   = '0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_ready", bus.ready, 1'b1);
      check("rst_valid_out", bus.valid_out, 1'b0);
      check("rst_out", bus.state_array_out, '0);

      // 1: all 0x63 -> all 0x00, latency 16 edges after accept
      bus.state_array = fill(8'h63);
      bus.valid       = 1'b1;
      step();
      bus.valid = 1'b0;
      check("t1_ready_drop", bus.ready, 1'b0);
      wait_done(n);
      check("t1_latency", n, 16);
      check("t1_out", bus.state_array_out, '0);

      // 4: backpressure in DONE, ignored valid pulse
      for (int i = 0; i < 20; i++) begin
         bus.valid = (i == 5);
         step();
         check("t4_valid_out", bus.valid_out, 1'b1);
         check("t4_ready", bus.ready, 1'b0);
         check("t4_out", bus.state_array_out, '0);
      end
      bus.valid         = 1'b0;
      bus.next_is_ready = 1'b1;
      step();
      check("t4_release_ready", bus.ready, 1'b1);
      check("t4_release_vout", bus.valid_out, 1'b0);
      step();
      check("t4_stay_idle", bus.ready, 1'b1);

      // 2: bytes 0x00..0x0f column-major, input scrambled after accept
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a_in[r][c]  = 8'(4 * c + r);
            a_exp[r][c] = EXP_LO[4 * c + r];
         end
      bus.next_is_ready = 1'b0;
      bus.state_array   = a_in;
      bus.valid         = 1'b1;
      step();
      bus.valid = 1'b0;
      for (int k = 0; k < 4; k++)
         bus.state_array[k] = {$urandom, $urandom};
      wait_done(n);
      check("t2_out", bus.state_array_out, a_exp);
      check("t2_out00", bus.state_array_out[0][0], 8'h52);
      check("t2_out10", bus.state_array_out[1][0], 8'h09);
      check("t2_out20", bus.state_array_out[2][0], 8'h6a);
      check("t2_out30", bus.state_array_out[3][0], 8'hd5);
      check("t2_out33", bus.state_array_out[3][3], 8'hfb);
      bus.next_is_ready = 1'b1;
      step();

      // 5: reset at byte 7, then all 0x16 -> all 0xff
      bus.state_array = a_in;
      bus.valid       = 1'b1;
      step();
      bus.valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_ready", bus.ready, 1'b1);
      check("t5_valid_out", bus.valid_out, 1'b0);
      check("t5_out", bus.state_array_out, '0);
      bus.state_array = fill(8'h16);
      bus.valid       = 1'b1;
      step();
      bus.valid = 1'b0;
      wait_done(n);
      check("t5_out_ff", bus.state_array_out, fill(8'hff));
      step();

      // 3: round trip through the forward S-box; first 16 arrays cover 0..255
      for (int t = 0; t < 1000; t++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               a_exp[r][c] = (t < 16) ? 8'(t * 16 + 4 * c + r) : 8'($urandom_range(255));
               a_in[r][c]  = SBOX[a_exp[r][c]];
            end
         bus.state_array = a_in;
         bus.valid       = 1'b1;
         step();
         bus.valid = 1'b0;
         wait_done(n);
         check("t3_roundtrip", bus.state_array_out, a_exp);
         step();
      end

      // 6: back-to-back with valid and next_is_ready held high
      bus.valid = 1'b1;
      prev_acc  = 0;
      for (int k = 0; k < 4; k++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               a_exp[r][c] = 8'(k * 37 + 4 * c + r + 100);
               a_in[r][c]  = SBOX[a_exp[r][c]];
            end
         bus.state_array = a_in;
         check("t6_ready_before", bus.ready, 1'b1);
         step();
         acc = cyc;
         check("t6_accepted", bus.ready, 1'b0);
         if (k > 0) check("t6_period", acc - prev_acc, 18);
         prev_acc = acc;
         wait_done(n);
         check("t6_out", bus.state_array_out, a_exp);
         step();
         check("t6_pulse", bus.valid_out, 1'b0);
      end
      bus.valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
